vend_txn_fsm: RTL and testbench

Main vending transaction controller. It sits directly upstream of the APB configuration store.
- Accepts item selections and currency, and drives the store's item-id, read-request and update-request interface.
- Consumes the store's item cost and item availability.
- Issues dispense and change pulses.

---
 rtl/vend_pkg.sv | 32 +++
 rtl/vend_txn_fsm_if.sv | 37 +++
 rtl/vend_cash_acc.sv | 58 +++++
 rtl/vend_txn_fsm.sv | 230 +++++++++++++++++++++++
 tb/tb_vend_txn_fsm.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending transaction controller.
//   - Data widths: item index, item cost / change, single currency value.
//   - ACC_W: width of the running cash total. It is one bit wider than a cost,
//     so the total cannot wrap before the cost is reached.
//   - vend_state_e: transaction controller states.
//   - txn_err_e: error codes reported on txn_error.
// ---------------------------------------------------------------------------
package vend_pkg;

    localparam int unsigned ITEM_ID_W = 10;
    localparam int unsigned COST_W    = 16;
    localparam int unsigned CUR_W     = 7;
    localparam int unsigned ACC_W     = COST_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_COLLECT  = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_CHANGE   = 3'd4
    } vend_state_e;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_INVALID_ID = 2'd1,
        ERR_SOLD_OUT   = 2'd2,
        ERR_ABORTED    = 2'd3
    } txn_err_e;

endpackage

// File: rtl/vend_txn_fsm_if.sv
// ---------------------------------------------------------------------------
// vend_txn_fsm_if
// Link between the transaction controller and the configuration store.
//   cfg_item_id          controller -> store  item index being looked up
//   cfg_item_read_req    controller -> store  lookup strobe
//   cfg_item_update_req  controller -> store  one pulse per dispensed item
//   item_cost            store -> controller  cost of cfg_item_id (combinational)
//   item_available       store -> controller  stock of cfg_item_id
// The controller uses the master modport; the store uses the slave modport.
// ---------------------------------------------------------------------------
interface vend_txn_fsm_if
    import vend_pkg::*;
();

    logic [ITEM_ID_W-1:0] cfg_item_id;
    logic                 cfg_item_read_req;
    logic                 cfg_item_update_req;
    logic [COST_W-1:0]    item_cost;
    logic [7:0]           item_available;

    modport master (
        output cfg_item_id,
        output cfg_item_read_req,
        output cfg_item_update_req,
        input  item_cost,
        input  item_available
    );

    modport slave (
        input  cfg_item_id,
        input  cfg_item_read_req,
        input  cfg_item_update_req,
        output item_cost,
        output item_available
    );

endinterface

// File: rtl/vend_cash_acc.sv
// ---------------------------------------------------------------------------
// vend_cash_acc
// Running cash total for one transaction.
// Ports:
//   pclk, prstn   clock, asynchronous active-low reset
//   clr           clear the total (takes priority over add)
//   add           add add_value to the total this cycle
//   add_value     value of the inserted currency
//   cost          latched cost of the selected item
//   total_ge      total >= cost
//   total_gt      total >  cost
//   total_nz      total != 0
//   diff          total - cost, meaningful only while total_gt is set
//   total_lo      total truncated to COST_W bits, used for refunds
// ---------------------------------------------------------------------------
module vend_cash_acc
    import vend_pkg::*;
(
    input  logic              pclk,
    input  logic              prstn,
    input  logic              clr,
    input  logic              add,
    input  logic [CUR_W-1:0]  add_value,
    input  logic [COST_W-1:0] cost,
    output logic              total_ge,
    output logic              total_gt,
    output logic              total_nz,
    output logic [COST_W-1:0] diff,
    output logic [COST_W-1:0] total_lo
);

    logic [ACC_W-1:0] total_q;
    logic [ACC_W-1:0] cost_ext;

    assign cost_ext = {1'b0, cost};

    // The total only grows while the controller is collecting. A clear at
    // the end of a transaction wins over any add in the same cycle.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            total_q <= '0;
        end else if (clr) begin
            total_q <= '0;
        end else if (add) begin
            total_q <= total_q + ACC_W'(add_value);
        end
    end

    assign total_ge = (total_q >= cost_ext);
    assign total_gt = (total_q >  cost_ext);
    assign total_nz = |total_q;
    assign total_lo = total_q[COST_W-1:0];

    // Change never exceeds one currency value, so a COST_W-bit modular
    // difference is exact whenever total exceeds cost.
    assign diff = total_q[COST_W-1:0] - cost;

endmodule

// File: rtl/vend_txn_fsm.sv
// ---------------------------------------------------------------------------
// vend_txn_fsm
// Vending transaction controller. Takes an item selection, looks the item up
// in the configuration store, collects currency until the cost is covered,
// dispenses the item and returns change.
// Ports:
//   pclk, prstn          clock, asynchronous active-low reset
//   cfg_mode             configuration mode; blocks new selections, and its
//                        rising edge aborts a lookup or collection
//   no_of_items          number of valid items in the store
//   item_select_valid/id one-cycle item selection
//   currency_valid/value one-cycle currency insertion
//   store                master side of vend_txn_fsm_if (store lookup/update)
//   item_dispense_valid  one-cycle dispense pulse, with item_dispense_id
//   change_valid         one-cycle change/refund pulse, with change_value
//   currency_reject      pulse one cycle after currency that was not accepted
//   txn_error            sticky error code, cleared by the next accepted select
// Optional feature:
//   VEND_TIMEOUT_EN      when defined, a collection with no currency for
//                        TIMEOUT_CYCLES cycles is aborted with a refund.
//                        Otherwise TIMEOUT_CYCLES is unused.
// ---------------------------------------------------------------------------
module vend_txn_fsm
    import vend_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                 pclk,
    input  logic                 prstn,
    input  logic                 cfg_mode,
    input  logic [ITEM_ID_W-1:0] no_of_items,
    input  logic                 item_select_valid,
    input  logic [ITEM_ID_W-1:0] item_select_id,
    input  logic                 currency_valid,
    input  logic [CUR_W-1:0]     currency_value,
    vend_txn_fsm_if.master       store,
    output logic                 item_dispense_valid,
    output logic [ITEM_ID_W-1:0] item_dispense_id,
    output logic                 change_valid,
    output logic [COST_W-1:0]    change_value,
    output logic                 currency_reject,
    output logic [1:0]           txn_error
);

    vend_state_e          state_q, state_d;
    logic [ITEM_ID_W-1:0] item_id_q;
    logic [COST_W-1:0]    cost_q;
    logic                 cfg_mode_q;
    txn_err_e             err_q, err_d;
    logic                 change_valid_q;
    logic [COST_W-1:0]    change_value_q;
    logic                 reject_q;

    logic                 load_id;
    logic                 load_cost;
    logic                 err_load;
    logic                 acc_clr;
    logic                 acc_add;
    logic                 chg_valid_d;
    logic [COST_W-1:0]    chg_value_d;
    logic                 mode_rise;
    logic                 timeout_hit;
    logic                 dispensing;

    logic                 acc_ge;
    logic                 acc_gt;
    logic                 acc_nz;
    logic [COST_W-1:0]    acc_diff;
    logic [COST_W-1:0]    acc_total_lo;

    vend_cash_acc u_cash_acc (
        .pclk      (pclk),
        .prstn     (prstn),
        .clr       (acc_clr),
        .add       (acc_add),
        .add_value (currency_value),
        .cost      (cost_q),
        .total_ge  (acc_ge),
        .total_gt  (acc_gt),
        .total_nz  (acc_nz),
        .diff      (acc_diff),
        .total_lo  (acc_total_lo)
    );

    assign mode_rise = cfg_mode && !cfg_mode_q;

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] idle_cnt_q;

    // Counts consecutive COLLECT cycles without currency; any currency or
    // leaving COLLECT restarts it.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            idle_cnt_q <= '0;
        end else if ((state_q != ST_COLLECT) || currency_valid) begin
            idle_cnt_q <= '0;
        end else if (!timeout_hit) begin
            idle_cnt_q <= idle_cnt_q + TO_W'(1);
        end
    end

    // Fires in the TIMEOUT_CYCLES-th idle cycle so the abort lands at its end.
    assign timeout_hit = (state_q == ST_COLLECT) && !currency_valid &&
                         (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // Keeps the parameter referenced in builds without the timeout.
    wire unused_timeout = |TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    // State, latched transaction context and the registered pulse outputs.
    // currency_reject follows any currency the FSM did not accumulate.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_q        <= ST_IDLE;
            item_id_q      <= '0;
            cost_q         <= '0;
            cfg_mode_q     <= 1'b0;
            err_q          <= ERR_NONE;
            change_valid_q <= 1'b0;
            change_value_q <= '0;
            reject_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cfg_mode_q     <= cfg_mode;
            change_valid_q <= chg_valid_d;
            change_value_q <= chg_value_d;
            reject_q       <= currency_valid && !acc_add;
            if (load_id) begin
                item_id_q <= item_select_id;
            end
            if (load_cost) begin
                cost_q <= store.item_cost;
            end
            if (err_load) begin
                err_q <= err_d;
            end
        end
    end

    // Next-state and control decode. COLLECT checks the registered total, so
    // the cycle after the completing currency is still COLLECT (rejecting any
    // more currency) and the dispense follows one cycle later.
    always_comb begin
        state_d     = state_q;
        load_id     = 1'b0;
        load_cost   = 1'b0;
        err_load    = 1'b0;
        err_d       = ERR_NONE;
        acc_clr     = 1'b0;
        acc_add     = 1'b0;
        chg_valid_d = 1'b0;
        chg_value_d = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (item_select_valid && !cfg_mode) begin
                    load_id  = 1'b1;
                    err_load = 1'b1;
                    err_d    = ERR_NONE;
                    state_d  = ST_LOOKUP;
                end
            end

            ST_LOOKUP: begin
                if (mode_rise) begin
                    err_load = 1'b1;
                    err_d    = ERR_ABORTED;
                    acc_clr  = 1'b1;
                    state_d  = ST_IDLE;
                end else if (item_id_q >= no_of_items) begin
                    err_load = 1'b1;
                    err_d    = ERR_INVALID_ID;
                    state_d  = ST_IDLE;
                end else if (store.item_available == '0) begin
                    err_load = 1'b1;
                    err_d    = ERR_SOLD_OUT;
                    state_d  = ST_IDLE;
                end else begin
                    load_cost = 1'b1;
                    state_d   = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (mode_rise || timeout_hit) begin
                    err_load    = 1'b1;
                    err_d       = ERR_ABORTED;
                    chg_valid_d = acc_nz;
                    chg_value_d = acc_total_lo;
                    acc_clr     = 1'b1;
                    state_d     = ST_IDLE;
                end else if (acc_ge) begin
                    state_d = ST_DISPENSE;
                end else if (currency_valid) begin
                    acc_add = 1'b1;
                end
            end

            ST_DISPENSE: begin
                state_d = ST_CHANGE;
            end

            ST_CHANGE: begin
                chg_valid_d = acc_gt;
                chg_value_d = acc_gt ? acc_diff : '0;
                acc_clr     = 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dispensing                = (state_q == ST_DISPENSE);
    assign store.cfg_item_id         = item_id_q;
    assign store.cfg_item_read_req   = (state_q == ST_LOOKUP);
    assign store.cfg_item_update_req = dispensing;
    assign item_dispense_valid       = dispensing;
    assign item_dispense_id          = dispensing ? item_id_q : '0;
    assign change_valid              = change_valid_q;
    assign change_value              = change_value_q;
    assign currency_reject           = reject_q;
    assign txn_error                 = err_q;

endmodule

// File: tb/tb_vend_txn_fsm.sv
// ---------------------------------------------------------------------------
// tb_vend_txn_fsm
// Directed bench for vend_txn_fsm with a four-entry store model:
//   item 0 cost 200 stock 1, item 1 cost 60 stock 3,
//   item 2 cost 150 stock 5, item 3 cost 30 stock 0 (sold out).
// Inputs change one cycle at a time through applyStimulus; outputs are
// sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_vend_txn_fsm;
    import vend_pkg::*;

    logic                 pclk;
    logic                 prstn;
    logic                 cfg_mode;
    logic [ITEM_ID_W-1:0] no_of_items;
    logic                 item_select_valid;
    logic [ITEM_ID_W-1:0] item_select_id;
    logic                 currency_valid;
    logic [CUR_W-1:0]     currency_value;
    logic                 item_dispense_valid;
    logic [ITEM_ID_W-1:0] item_dispense_id;
    logic                 change_valid;
    logic [COST_W-1:0]    change_value;
    logic                 currency_reject;
    logic [1:0]           txn_error;

    logic [COST_W-1:0]    cost_mem  [4];
    logic [7:0]           avail_mem [4];

    int checks = 0;
    int errors = 0;
    int pulse_count;

    vend_txn_fsm_if store_bus ();

    // Store model: combinational cost/stock for the presented id.
    assign store_bus.item_cost      = (store_bus.cfg_item_id < 10'd4) ?
                                      cost_mem[store_bus.cfg_item_id[1:0]] : '0;
    assign store_bus.item_available = (store_bus.cfg_item_id < 10'd4) ?
                                      avail_mem[store_bus.cfg_item_id[1:0]] : '0;

    vend_txn_fsm #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk                (pclk),
        .prstn               (prstn),
        .cfg_mode            (cfg_mode),
        .no_of_items         (no_of_items),
        .item_select_valid   (item_select_valid),
        .item_select_id      (item_select_id),
        .currency_valid      (currency_valid),
        .currency_value      (currency_value),
        .store               (store_bus.master),
        .item_dispense_valid (item_dispense_valid),
        .item_dispense_id    (item_dispense_id),
        .change_valid        (change_valid),
        .change_value        (change_value),
        .currency_reject     (currency_reject),
        .txn_error           (txn_error)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, step past the edge, then drop the pulses.
    task automatic applyStimulus(input logic sel, input logic [ITEM_ID_W-1:0] sid,
                                 input logic cur, input logic [CUR_W-1:0] cval,
                                 input logic mode);
        item_select_valid = sel;
        item_select_id    = sid;
        currency_valid    = cur;
        currency_value    = cval;
        cfg_mode          = mode;
        @(posedge pclk);
        #1;
        item_select_valid = 1'b0;
        currency_valid    = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        cost_mem[0] = 16'd200; avail_mem[0] = 8'd1;
        cost_mem[1] = 16'd60;  avail_mem[1] = 8'd3;
        cost_mem[2] = 16'd150; avail_mem[2] = 8'd5;
        cost_mem[3] = 16'd30;  avail_mem[3] = 8'd0;

        prstn             = 1'b0;
        cfg_mode          = 1'b0;
        no_of_items       = 10'd4;
        item_select_valid = 1'b0;
        item_select_id    = '0;
        currency_valid    = 1'b0;
        currency_value    = '0;
        repeat (2) @(posedge pclk);
        #1;
        $display("[TB] reset state");
        checkOutput("rst_dispense", item_dispense_valid, 0);
        checkOutput("rst_change_valid", change_valid, 0);
        checkOutput("rst_change_value", change_value, 0);
        checkOutput("rst_reject", currency_reject, 0);
        checkOutput("rst_txn_error", txn_error, 0);
        checkOutput("rst_item_id", store_bus.cfg_item_id, 0);
        checkOutput("rst_read_req", store_bus.cfg_item_read_req, 0);
        prstn = 1'b1;
        @(posedge pclk);
        #1;

        // Item 2 cost 150: 100 + 100, extra 5 after cost reached -> change 50.
        $display("[TB] purchase with change");
        applyStimulus(1'b1, 10'd2, 1'b0, '0, 1'b0);
        checkOutput("t1_read_req", store_bus.cfg_item_read_req, 1);
        checkOutput("t1_item_id", store_bus.cfg_item_id, 2);
        idleCycle();
        checkOutput("t1_read_req_off", store_bus.cfg_item_read_req, 0);
        applyStimulus(1'b0, '0, 1'b1, 7'd100, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 7'd100, 1'b0);
        checkOutput("t1_no_early_dispense", item_dispense_valid, 0);
        applyStimulus(1'b0, '0, 1'b1, 7'd5, 1'b0);
        checkOutput("t1_extra_rejected", currency_reject, 1);
        checkOutput("t1_dispense", item_dispense_valid, 1);
        checkOutput("t1_dispense_id", item_dispense_id, 2);
        checkOutput("t1_update_req", store_bus.cfg_item_update_req, 1);
        checkOutput("t1_item_id_held", store_bus.cfg_item_id, 2);
        idleCycle();
        checkOutput("t1_update_req_off", store_bus.cfg_item_update_req, 0);
        checkOutput("t1_dispense_off", item_dispense_valid, 0);
        idleCycle();
        checkOutput("t1_change_valid", change_valid, 1);
        checkOutput("t1_change_value", change_value, 50);
        idleCycle();
        checkOutput("t1_change_off", change_valid, 0);

        // Item 1 cost 60: 50 + 10 exact -> dispense, no change.
        $display("[TB] exact payment");
        applyStimulus(1'b1, 10'd1, 1'b0, '0, 1'b0);
        idleCycle();
        applyStimulus(1'b0, '0, 1'b1, 7'd50, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 7'd10, 1'b0);
        idleCycle();
        checkOutput("t2_dispense", item_dispense_valid, 1);
        checkOutput("t2_dispense_id", item_dispense_id, 1);
        idleCycle();
        idleCycle();
        checkOutput("t2_no_change", change_valid, 0);
        checkOutput("t2_txn_error", txn_error, 0);

        // Invalid id, then sold-out item.
        $display("[TB] lookup errors");
        applyStimulus(1'b1, 10'd7, 1'b0, '0, 1'b0);
        checkOutput("t3_read_req", store_bus.cfg_item_read_req, 1);
        idleCycle();
        checkOutput("t3_err_invalid", txn_error, 1);
        idleCycle();
        checkOutput("t3_no_dispense", item_dispense_valid, 0);
        checkOutput("t3_no_update", store_bus.cfg_item_update_req, 0);
        checkOutput("t3_err_sticky", txn_error, 1);
        applyStimulus(1'b1, 10'd3, 1'b0, '0, 1'b0);
        checkOutput("t3_err_cleared", txn_error, 0);
        idleCycle();
        checkOutput("t3_err_sold_out", txn_error, 2);

        // Item 0 cost 200: 50 + 20, then currency together with cfg_mode rise.
        $display("[TB] abort with refund");
        applyStimulus(1'b1, 10'd0, 1'b0, '0, 1'b0);
        idleCycle();
        applyStimulus(1'b0, '0, 1'b1, 7'd50, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 7'd20, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 7'd30, 1'b1);
        checkOutput("t4_reject", currency_reject, 1);
        checkOutput("t4_refund_valid", change_valid, 1);
        checkOutput("t4_refund_value", change_value, 70);
        checkOutput("t4_err_aborted", txn_error, 3);
        idleCycle();
        checkOutput("t4_refund_off", change_valid, 0);
        applyStimulus(1'b1, 10'd1, 1'b0, '0, 1'b0);
        checkOutput("t4_back_in_idle", store_bus.cfg_item_read_req, 1);
        idleCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("t4_abort_no_refund", change_valid, 0);
        checkOutput("t4_abort_err", txn_error, 3);
        idleCycle();

        // Currency in IDLE, select during COLLECT, exact payment for item 2.
        $display("[TB] rejects and ignored select");
        applyStimulus(1'b0, '0, 1'b1, 7'd20, 1'b0);
        checkOutput("t5_idle_reject", currency_reject, 1);
        checkOutput("t5_idle_no_change", change_valid, 0);
        idleCycle();
        checkOutput("t5_reject_off", currency_reject, 0);
        applyStimulus(1'b1, 10'd2, 1'b0, '0, 1'b0);
        idleCycle();
        applyStimulus(1'b0, '0, 1'b1, 7'd100, 1'b0);
        applyStimulus(1'b1, 10'd1, 1'b0, '0, 1'b0);
        checkOutput("t5_id_unchanged", store_bus.cfg_item_id, 2);
        checkOutput("t5_no_lookup", store_bus.cfg_item_read_req, 0);
        applyStimulus(1'b0, '0, 1'b1, 7'd50, 1'b0);
        idleCycle();
        checkOutput("t5_dispense", item_dispense_valid, 1);
        checkOutput("t5_dispense_id", item_dispense_id, 2);
        idleCycle();
        idleCycle();
        checkOutput("t5_no_change", change_valid, 0);

        // Collection left idle: item 1 cost 60 with 10 inserted.
        $display("[TB] idle collection");
        applyStimulus(1'b1, 10'd1, 1'b0, '0, 1'b0);
        idleCycle();
        applyStimulus(1'b0, '0, 1'b1, 7'd10, 1'b0);
        pulse_count = 0;
`ifdef VEND_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            idleCycle();
            if (change_valid || (txn_error != 2'd0)) pulse_count++;
        end
        checkOutput("t6_no_early_timeout", pulse_count, 0);
        idleCycle();
        checkOutput("t6_timeout_refund", change_valid, 1);
        checkOutput("t6_timeout_value", change_value, 10);
        checkOutput("t6_timeout_err", txn_error, 3);
        idleCycle();
`else
        for (int i = 0; i < 100; i++) begin
            idleCycle();
            if (change_valid || (txn_error != 2'd0)) pulse_count++;
        end
        checkOutput("t6_still_waiting", pulse_count, 0);
        applyStimulus(1'b0, '0, 1'b1, 7'd50, 1'b0);
        checkOutput("t6_accepted", currency_reject, 0);
        idleCycle();
        checkOutput("t6_dispense", item_dispense_valid, 1);
        checkOutput("t6_dispense_id", item_dispense_id, 1);
        idleCycle();
        idleCycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
